// File: rtl/stop_digit_scan.sv
// rtl/stop_digit_scan.sv - multiplexed seven-segment digit scanner with frame snapshot,
// guard interval, leading-zero blanking and frame tick.
module stop_digit_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int GUARD          = 8,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lz_blank,
  output logic [NUM_DIGITS-1:0]         selectorBus,
  output logic [3:0]                    digit_out,
  output logic                          dp_out,
  output logic                          blank_out,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    primed_q, primed_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    slot_end, frame_end, snap_load;
  logic                    guard_ok, active, zero_run, suppress, dp_sel;
  logic [3:0]              digit_sel;
  logic [NUM_DIGITS-1:0]   sel_raw;

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_dig_d   = snap_dig_q;
    snap_dp_d    = snap_dp_q;
    primed_d     = primed_q;
    frame_tick_d = 1'b0;
    snap_load    = 1'b0;
    slot_end     = (cnt_q == CW'(PRESCALE - 1));
    frame_end    = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    if (en) begin
      // The priming edge only captures the first frame; counting starts on the next edge.
      if (!primed_q) begin
        primed_d  = 1'b1;
        snap_load = 1'b1;
      end else begin
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        snap_load = frame_end;
        if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
      end
    end
    if (snap_load) begin
      snap_dig_d   = digits_in;
      snap_dp_d    = dp_in;
      frame_tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      primed_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      primed_q     <= primed_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  if (GUARD == 0) begin : g_noguard
    assign guard_ok = 1'b1;
  end else begin : g_guard
    assign guard_ok = (cnt_q >= CW'(GUARD));
  end

  // primed_q clears asynchronously, so reset drops the selector without a clock edge.
  assign active = en && primed_q && guard_ok;

  always_comb begin
    zero_run  = 1'b1;
    digit_sel = 4'h0;
    dp_sel    = 1'b0;
    sel_raw   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) >= idx_q && snap_dig_q[4*k +: 4] != 4'h0) zero_run = 1'b0;
      if (IW'(k) == idx_q) begin
        digit_sel  = snap_dig_q[4*k +: 4];
        dp_sel     = snap_dp_q[k];
        sel_raw[k] = active;
      end
    end
  end

  assign suppress    = lz_blank && (idx_q != '0) && zero_run;
  assign selectorBus = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
  assign digit_out   = digit_sel;
  assign dp_out      = dp_sel && active && !suppress;
  assign blank_out   = !active || suppress;
  assign scan_idx    = idx_q;
  assign frame_tick  = frame_tick_q && en;

endmodule

// File: tb/tb_stop_digit_scan.sv
// tb/tb_stop_digit_scan.sv - directed scoreboard bench for stop_digit_scan (4-digit
// active-low guarded instance and 6-digit active-high unguarded instance).
module tb_stop_digit_scan;

  typedef struct packed {
    logic [7:0] sel;
    logic [3:0] digit;
    logic       dp;
    logic       blank;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, en, lz_blank;
  logic [15:0] digits_a;
  logic [3:0]  dp_a;
  logic [3:0]  sel_a, digit_a;
  logic        dp_out_a, blank_a, tick_a;
  logic [1:0]  idx_a;

  logic [23:0] digits_b;
  logic [5:0]  dp_b;
  logic        lz_b;
  logic [5:0]  sel_b;
  logic [3:0]  digit_b;
  logic        dp_out_b, blank_b, tick_b;
  logic [2:0]  idx_b;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  stop_digit_scan #(.NUM_DIGITS(4), .PRESCALE(4), .GUARD(1), .SEL_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_a), .dp_in(dp_a),
    .lz_blank(lz_blank), .selectorBus(sel_a), .digit_out(digit_a), .dp_out(dp_out_a),
    .blank_out(blank_a), .scan_idx(idx_a), .frame_tick(tick_a)
  );

  stop_digit_scan #(.NUM_DIGITS(6), .PRESCALE(4), .GUARD(0), .SEL_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_b), .dp_in(dp_b),
    .lz_blank(lz_b), .selectorBus(sel_b), .digit_out(digit_b), .dp_out(dp_out_b),
    .blank_out(blank_b), .scan_idx(idx_b), .frame_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sup marks digits that the frame's leading-zero rule hides (derived by hand per frame).
  function automatic exp_t mk_a(input int k, input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] sup);
    exp_t e;
    int   cnt, idx;
    logic act;
    cnt     = k % 4;
    idx     = (k / 4) % 4;
    act     = (cnt >= 1);
    e.sel   = act ? (~(8'd1 << idx) & 8'h0F) : 8'h0F;
    e.digit = d[idx*4 +: 4];
    e.dp    = act && dp[idx] && !sup[idx];
    e.blank = !act || sup[idx];
    e.idx   = 3'(idx);
    e.tick  = (k % 16 == 0);
    return e;
  endfunction

  function automatic exp_t mk_b(input int k, input logic [23:0] d, input logic [5:0] dp);
    exp_t e;
    int   idx;
    idx     = (k / 4) % 6;
    e.sel   = 8'd1 << idx;
    e.digit = d[idx*4 +: 4];
    e.dp    = dp[idx];
    e.blank = 1'b0;
    e.idx   = 3'(idx);
    e.tick  = (k % 24 == 0);
    return e;
  endfunction

  task automatic cmp(input string who, input int k, input exp_t e,
                     input logic [7:0] sel, input logic [3:0] dg, input logic dp,
                     input logic bl, input logic [2:0] ix, input logic tk);
    chk($sformatf("%s_sel k=%0d", who, k), sel, e.sel);
    chk($sformatf("%s_digit k=%0d", who, k), dg, e.digit);
    chk($sformatf("%s_dp k=%0d", who, k), dp, e.dp);
    chk($sformatf("%s_blank k=%0d", who, k), bl, e.blank);
    chk($sformatf("%s_idx k=%0d", who, k), ix, e.idx);
    chk($sformatf("%s_tick k=%0d", who, k), tk, e.tick);
  endtask

  logic [15:0] fr_d[7]   = '{16'h4321, 16'h4321, 16'h4321, 16'h8765, 16'h0050, 16'h0000, 16'h4321};
  logic [3:0]  fr_dp[7]  = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1111, 4'b1111, 4'b0000};
  logic [3:0]  fr_sup[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1110, 4'b0000};

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    en       = 1'b1;
    lz_blank = 1'b0;
    lz_b     = 1'b0;
    digits_a = 16'h4321;
    dp_a     = 4'b0101;
    digits_b = 24'h654321;
    dp_b     = 6'b100001;
    #22;
    chk("rst_sel_a", sel_a, 4'b1111);
    chk("rst_blank_a", blank_a, 1'b1);
    chk("rst_digit_a", digit_a, 4'h0);
    chk("rst_dp_a", dp_out_a, 1'b0);
    chk("rst_idx_a", idx_a, 2'd0);
    chk("rst_tick_a", tick_a, 1'b0);
    chk("rst_sel_b", sel_b, 6'b000000);
    rst_n = 1'b1;
    #1;
    chk("unprimed_sel_a", sel_a, 4'b1111);
    chk("unprimed_sel_b", sel_b, 6'b000000);
    chk("unprimed_blank_b", blank_b, 1'b1);

    for (int k = 0; k <= 106; k++) qa.push_back(mk_a(k, fr_d[k/16], fr_dp[k/16], fr_sup[k/16]));
    for (int k = 0; k < 48; k++) qb.push_back(mk_b(k, digits_b, dp_b));

    for (int k = 0; k <= 106; k++) begin
      step();
      e = qa.pop_front();
      cmp("a", k, e, {4'b0, sel_a}, digit_a, dp_out_a, blank_a, {1'b0, idx_a}, tick_a);
      if (k < 48) begin
        e = qb.pop_front();
        cmp("b", k, e, {2'b0, sel_b}, digit_b, dp_out_b, blank_b, idx_b, tick_b);
      end
      case (k)
        36: digits_a = 16'h8765;
        63: begin digits_a = 16'h0050; dp_a = 4'b1111; lz_blank = 1'b1; end
        79: digits_a = 16'h0000;
        95: begin digits_a = 16'h4321; dp_a = 4'b0000; lz_blank = 1'b0; end
        default: ;
      endcase
    end

    en = 1'b0;
    #1;
    chk("hold_sel_now", sel_a, 4'b1111);
    chk("hold_blank_now", blank_a, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold_sel %0d", i), sel_a, 4'b1111);
      chk($sformatf("hold_blank %0d", i), blank_a, 1'b1);
      chk($sformatf("hold_idx %0d", i), idx_a, 2'd2);
      chk($sformatf("hold_tick %0d", i), tick_a, 1'b0);
    end
    en = 1'b1;
    #1;
    chk("resume_sel", sel_a, 4'b1011);
    chk("resume_idx", idx_a, 2'd2);
    chk("resume_digit", digit_a, 4'h3);
    step();
    chk("resume_sel_cnt3", sel_a, 4'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", sel_a, 4'b1111);
    chk("async_rst_blank", blank_a, 1'b1);
    chk("async_rst_idx", idx_a, 2'd0);
    chk("async_rst_digit", digit_a, 4'h0);
    chk("async_rst_sel_b", sel_b, 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
